// File: rtl/gtp_frame_parser_if.sv
// ============================================================================
//  Module      : gtp_frame_parser_if
//  Description : Bundle of the lane-side, FIFO-side and error-counter signals
//                of one gtp_frame_parser lane.
//                slave  modport : the parser itself
//                master modport : the lane/FIFO/control side driving it
//  Signals     : gtp_dat/gtp_kchar (lane in), out_dat/out_vld (FIFO out),
//                frm_done/frm_bad (frame status), cnt_clr (counter clear in),
//                err_crc/err_trunc/err_hdr (error counters out)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gtp_frame_parser_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      gtp_dat;
    logic             gtp_kchar;
    logic [15:0]      out_dat;
    logic             out_vld;
    logic             frm_done;
    logic             frm_bad;
    logic             cnt_clr;
    logic [CNT_W-1:0] err_crc;
    logic [CNT_W-1:0] err_trunc;
    logic [CNT_W-1:0] err_hdr;

    modport slave (
        input  gtp_dat, gtp_kchar, cnt_clr,
        output out_dat, out_vld, frm_done, frm_bad,
        output err_crc, err_trunc, err_hdr
    );

    modport master (
        output gtp_dat, gtp_kchar, cnt_clr,
        input  out_dat, out_vld, frm_done, frm_bad,
        input  err_crc, err_trunc, err_hdr
    );
endinterface

`default_nettype wire

// File: rtl/gtp_frame_parser.sv
// ============================================================================
//  Module      : gtp_frame_parser
//  Description : Per-lane frame checker. Delineates header/payload/trailer
//                frames on a 16-bit GTP lane, checks the header length and the
//                XOR checksum, forwards header+payload with one registered
//                cycle of delay and reports each frame good/bad.
//  Ports       : clk  - lane clock (CLK125), the only clock
//                rst  - asynchronous active-high reset
//                bus  - gtp_frame_parser_if.slave (lane in, FIFO out,
//                       frame status, error counters)
//  Config      : FRAME_ERRCNT_EN - when defined, builds the saturating
//                err_crc / err_trunc / err_hdr counters with cnt_clr;
//                otherwise the counters read 0 and cnt_clr is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gtp_frame_parser #(
    parameter int MAX_LEN = 512,
    parameter int CNT_W   = 16
) (
    input  wire                        clk,
    input  wire                        rst,
    gtp_frame_parser_if.slave          bus
);

    localparam logic [11:0] c_MAX_LEN = 12'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PAYLOAD = 2'd1,
        S_TRAILER = 2'd2
    } state_t;

    state_t      state_q,    state_d;
    logic [11:0] rem_q,      rem_d;
    logic [15:0] acc_q,      acc_d;
    logic [15:0] out_dat_q,  out_dat_d;
    logic        out_vld_q,  out_vld_d;
    logic        frm_done_q, frm_done_d;
    logic        frm_bad_q,  frm_bad_d;

    // One-cycle error strobes feeding the counters
    logic        w_err_hdr;
    logic        w_err_trunc;
    logic        w_err_crc;
    logic        w_hdr_ok;

    assign w_hdr_ok = bus.gtp_dat[15]
                   && (bus.gtp_dat[11:0] != 12'd0)
                   && (bus.gtp_dat[11:0] <= c_MAX_LEN);

    // ------------------------------------------------------------------------
    // State / datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_q      <= 12'd0;
            acc_q      <= 16'd0;
            out_dat_q  <= 16'd0;
            out_vld_q  <= 1'b0;
            frm_done_q <= 1'b0;
            frm_bad_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            out_dat_q  <= out_dat_d;
            out_vld_q  <= out_vld_d;
            frm_done_q <= frm_done_d;
            frm_bad_q  <= frm_bad_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        out_dat_d   = out_dat_q;
        out_vld_d   = 1'b0;
        frm_done_d  = 1'b0;
        frm_bad_d   = 1'b0;
        w_err_hdr   = 1'b0;
        w_err_trunc = 1'b0;
        w_err_crc   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.gtp_kchar) begin
                    if (w_hdr_ok) begin
                        rem_d     = bus.gtp_dat[11:0];
                        acc_d     = bus.gtp_dat;
                        out_dat_d = bus.gtp_dat;
                        out_vld_d = 1'b1;
                        state_d   = S_PAYLOAD;
                    end else begin
                        w_err_hdr = 1'b1;
                    end
                end
            end

            S_PAYLOAD: begin
                // No resync inside a frame: any non-K word is payload.
                if (!bus.gtp_kchar) begin
                    acc_d     = acc_q ^ bus.gtp_dat;
                    rem_d     = rem_q - 12'd1;
                    out_dat_d = bus.gtp_dat;
                    out_vld_d = 1'b1;
                    if (rem_q == 12'd1) begin
                        state_d = S_TRAILER;
                    end
                end else begin
                    frm_done_d  = 1'b1;
                    frm_bad_d   = 1'b1;
                    w_err_trunc = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            S_TRAILER: begin
                frm_done_d = 1'b1;
                state_d    = S_IDLE;
                if (!bus.gtp_kchar) begin
                    frm_bad_d = (bus.gtp_dat != acc_q);
                    w_err_crc = (bus.gtp_dat != acc_q);
                end else begin
                    frm_bad_d   = 1'b1;
                    w_err_trunc = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.out_dat  = out_dat_q;
    assign bus.out_vld  = out_vld_q;
    assign bus.frm_done = frm_done_q;
    assign bus.frm_bad  = frm_bad_q;

    // ------------------------------------------------------------------------
    // Error counters
    // ------------------------------------------------------------------------
`ifdef FRAME_ERRCNT_EN
    logic [CNT_W-1:0] err_crc_q;
    logic [CNT_W-1:0] err_trunc_q;
    logic [CNT_W-1:0] err_hdr_q;

    // Clear wins over a same-cycle increment; counts stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_crc_q   <= '0;
            err_trunc_q <= '0;
            err_hdr_q   <= '0;
        end else if (bus.cnt_clr) begin
            err_crc_q   <= '0;
            err_trunc_q <= '0;
            err_hdr_q   <= '0;
        end else begin
            if (w_err_crc && (err_crc_q != '1)) begin
                err_crc_q <= err_crc_q + 1'b1;
            end
            if (w_err_trunc && (err_trunc_q != '1)) begin
                err_trunc_q <= err_trunc_q + 1'b1;
            end
            if (w_err_hdr && (err_hdr_q != '1)) begin
                err_hdr_q <= err_hdr_q + 1'b1;
            end
        end
    end

    assign bus.err_crc   = err_crc_q;
    assign bus.err_trunc = err_trunc_q;
    assign bus.err_hdr   = err_hdr_q;
`else
    assign bus.err_crc   = '0;
    assign bus.err_trunc = '0;
    assign bus.err_hdr   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gtp_frame_parser.sv
// ============================================================================
//  Module      : tb_gtp_frame_parser
//  Description : Directed self-checking bench for gtp_frame_parser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gtp_frame_parser;

    localparam int c_MAX_LEN = 512;
    localparam int c_CNT_W   = 16;
    localparam logic [15:0] c_K = 16'hBCBC;

    logic clk;
    logic rst;

    gtp_frame_parser_if #(.CNT_W(c_CNT_W)) bus ();

    gtp_frame_parser #(
        .MAX_LEN (c_MAX_LEN),
        .CNT_W   (c_CNT_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // ------------------------------------------------------------------------
    // Output recorder (samples on the falling edge)
    // ------------------------------------------------------------------------
    logic [15:0] r_words[$];
    int          r_done_cnt;
    int          r_bad_cnt;
    int          r_timing_err;
    logic        r_prev_vld;

    initial begin
        r_done_cnt   = 0;
        r_bad_cnt    = 0;
        r_timing_err = 0;
        r_prev_vld   = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.out_vld) r_words.push_back(bus.out_dat);
        if (bus.frm_done) begin
            r_done_cnt++;
            if (bus.frm_bad) r_bad_cnt++;
            if (!r_prev_vld) r_timing_err++;
        end
        r_prev_vld = bus.out_vld;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send(input logic k, input logic [15:0] d);
        @(negedge clk);
        bus.gtp_kchar = k;
        bus.gtp_dat   = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b1, c_K);
    endtask

    // Clear the recorder on the rising edge, away from the recorder process.
    task automatic clr_rec();
        @(posedge clk);
        r_words.delete();
        r_done_cnt = 0;
        r_bad_cnt  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    logic [15:0] v_acc;
    logic [15:0] v_p;
    logic [15:0] v_last;

    initial begin
        rst           = 1'b1;
        bus.gtp_kchar = 1'b1;
        bus.gtp_dat   = c_K;
        bus.cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_vld",  32'(bus.out_vld),  32'd0);
        check("rst_out_dat",  32'(bus.out_dat),  32'd0);
        check("rst_frm_done", 32'(bus.frm_done), 32'd0);
        check("rst_frm_bad",  32'(bus.frm_bad),  32'd0);
        check("rst_err_crc",  32'(bus.err_crc),  32'd0);
        check("rst_err_hdr",  32'(bus.err_hdr),  32'd0);
        rst = 1'b0;
        idle(2);
        clr_rec();

        // 1) Good frame
        send(1'b0, 16'h8003); send(1'b0, 16'h0001);
        send(1'b0, 16'h0002); send(1'b0, 16'h0004);
        send(1'b0, 16'h8004);
        idle(3);
        check("t1_nwords", 32'(r_words.size()), 32'd4);
        if (r_words.size() == 4) begin
            check("t1_w0", 32'(r_words[0]), 32'h8003);
            check("t1_w1", 32'(r_words[1]), 32'h0001);
            check("t1_w2", 32'(r_words[2]), 32'h0002);
            check("t1_w3", 32'(r_words[3]), 32'h0004);
        end
        check("t1_done", 32'(r_done_cnt), 32'd1);
        check("t1_bad",  32'(r_bad_cnt),  32'd0);
        check("t1_err_crc", 32'(bus.err_crc), 32'd0);
        clr_rec();

        // 2) Checksum error
        send(1'b0, 16'h8003); send(1'b0, 16'h0001);
        send(1'b0, 16'h0002); send(1'b0, 16'h0004);
        send(1'b0, 16'h8005);
        idle(3);
        check("t2_nwords", 32'(r_words.size()), 32'd4);
        if (r_words.size() == 4) check("t2_w3", 32'(r_words[3]), 32'h0004);
        check("t2_done", 32'(r_done_cnt), 32'd1);
        check("t2_bad",  32'(r_bad_cnt),  32'd1);
`ifdef FRAME_ERRCNT_EN
        check("t2_err_crc", 32'(bus.err_crc), 32'd1);
`endif
        clr_rec();

        // 3) Truncation
        send(1'b0, 16'h8004); send(1'b0, 16'h0011); send(1'b0, 16'h0022);
        idle(3);
        check("t3_nwords", 32'(r_words.size()), 32'd3);
        check("t3_done", 32'(r_done_cnt), 32'd1);
        check("t3_bad",  32'(r_bad_cnt),  32'd1);
`ifdef FRAME_ERRCNT_EN
        check("t3_err_trunc", 32'(bus.err_trunc), 32'd1);
`endif
        clr_rec();

        // 4) Bad headers, then a maximum-length frame
        send(1'b0, 16'h1234);
        send(1'b0, 16'h8000);
        send(1'b0, 16'h8000 | 16'(c_MAX_LEN + 1));
        idle(3);
        check("t4_rej_nwords", 32'(r_words.size()), 32'd0);
        check("t4_rej_done",   32'(r_done_cnt),     32'd0);
`ifdef FRAME_ERRCNT_EN
        check("t4_err_hdr", 32'(bus.err_hdr), 32'd3);
`endif
        v_acc = 16'h8000 | 16'(c_MAX_LEN);
        send(1'b0, v_acc);
        v_last = 16'h0;
        for (int i = 0; i < c_MAX_LEN; i++) begin
            v_p    = 16'(i * 7 + 3);
            v_acc  = v_acc ^ v_p;
            v_last = v_p;
            send(1'b0, v_p);
        end
        send(1'b0, v_acc);
        idle(3);
        check("t4_max_nwords", 32'(r_words.size()), 32'(c_MAX_LEN + 1));
        if (r_words.size() == c_MAX_LEN + 1) begin
            check("t4_max_hdr",  32'(r_words[0]),         32'h8200);
            check("t4_max_last", 32'(r_words[c_MAX_LEN]), 32'(v_last));
        end
        check("t4_max_done", 32'(r_done_cnt), 32'd1);
        check("t4_max_bad",  32'(r_bad_cnt),  32'd0);
        clr_rec();

        // 5) Back-to-back frames: 8001^00AA=80AB, 8002^0011^0022=8031
        send(1'b0, 16'h8001); send(1'b0, 16'h00AA); send(1'b0, 16'h80AB);
        send(1'b0, 16'h8002); send(1'b0, 16'h0011); send(1'b0, 16'h0022);
        send(1'b0, 16'h8031);
        idle(3);
        check("t5_nwords", 32'(r_words.size()), 32'd5);
        if (r_words.size() == 5) begin
            check("t5_w2", 32'(r_words[2]), 32'h8002);
            check("t5_w4", 32'(r_words[4]), 32'h0022);
        end
        check("t5_done", 32'(r_done_cnt), 32'd2);
        check("t5_bad",  32'(r_bad_cnt),  32'd0);
        clr_rec();

`ifdef FRAME_ERRCNT_EN
        // Clear coincident with a header error: clear wins
        @(negedge clk);
        bus.gtp_kchar = 1'b0;
        bus.gtp_dat   = 16'h1234;
        bus.cnt_clr   = 1'b1;
        @(negedge clk);
        bus.gtp_kchar = 1'b1;
        bus.gtp_dat   = c_K;
        bus.cnt_clr   = 1'b0;
        check("clr_err_hdr",   32'(bus.err_hdr),   32'd0);
        check("clr_err_crc",   32'(bus.err_crc),   32'd0);
        check("clr_err_trunc", 32'(bus.err_trunc), 32'd0);
        clr_rec();
`endif

        // 6) Reset mid-frame
        send(1'b0, 16'h8004); send(1'b0, 16'h0001); send(1'b0, 16'h0002);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_vld", 32'(bus.out_vld),  32'd0);
        check("t6_rst_dat", 32'(bus.out_dat),  32'd0);
        check("t6_rst_done", 32'(bus.frm_done), 32'd0);
        bus.gtp_kchar = 1'b1;
        bus.gtp_dat   = c_K;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        check("t6_no_done", 32'(r_done_cnt), 32'd0);
        clr_rec();
        // 8001 ^ 0005 = 8004
        send(1'b0, 16'h8001); send(1'b0, 16'h0005); send(1'b0, 16'h8004);
        idle(3);
        check("t6_nwords", 32'(r_words.size()), 32'd2);
        if (r_words.size() == 2) check("t6_w1", 32'(r_words[1]), 32'h0005);
        check("t6_done", 32'(r_done_cnt), 32'd1);
        check("t6_bad",  32'(r_bad_cnt),  32'd0);

        check("done_timing", 32'(r_timing_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
